// File: rtl/motor_ramp_ctrl.sv
// rtl/motor_ramp_ctrl.sv - two-wheel duty ramp and lost-line recovery sequencer
module motor_ramp_ctrl #(
  parameter int unsigned TICK_DIV     = 100000,
  parameter logic [9:0]  STEP         = 10'd50,
  parameter logic [15:0] LOST_TICKS   = 16'd300,
  parameter logic [15:0] SEARCH_TICKS = 16'd2000,
  parameter logic [9:0]  SEARCH_FAST  = 10'd700,
  parameter logic [9:0]  SEARCH_SLOW  = 10'd200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [2:0] mode,
  output logic [9:0] left_duty,
  output logic [9:0] right_duty,
  output logic [1:0] state,
  output logic       at_target
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_SEARCH = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_MAX = CW'(TICK_DIV - 1);

  state_t        cur_state, nxt_state;
  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic          start_q;
  logic          start_edge;
  logic          last_side;
  logic [15:0]   lost_cnt, lost_nxt, lost_inc;
  logic [15:0]   search_cnt, search_nxt, search_inc;
  logic [9:0]    tgt_l, tgt_r;

  assign tick       = (tick_cnt == TICK_MAX);
  assign start_edge = start & ~start_q;
  assign lost_inc   = (lost_cnt == 16'hFFFF) ? lost_cnt : lost_cnt + 16'd1;
  assign search_inc = (search_cnt == 16'hFFFF) ? search_cnt : search_cnt + 16'd1;
  assign state      = cur_state;
  assign at_target  = (left_duty == tgt_l) && (right_duty == tgt_r);

  // Move one duty at most STEP toward its target; 11-bit sums avoid wrap
  function automatic logic [9:0] ramp_step(input logic [9:0] cur, input logic [9:0] tgt);
    logic [10:0] up;
    logic [10:0] lim;
    up  = {1'b0, cur} + {1'b0, STEP};
    lim = {1'b0, tgt} + {1'b0, STEP};
    if (cur < tgt)
      ramp_step = (up < {1'b0, tgt}) ? up[9:0] : tgt;
    else if (cur > tgt)
      ramp_step = ({1'b0, cur} > lim) ? (cur - STEP) : tgt;
    else
      ramp_step = cur;
  endfunction

  // Free-running ramp tick divider
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + 1'b1;
  end

  // Previous start level for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) start_q <= 1'b0;
    else start_q <= start;
  end

  // Remember which side the line was last seen on while tracking or searching
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_side <= 1'b0;
    else if (cur_state == S_RUN || cur_state == S_SEARCH) begin
      if (mode[2] && !mode[0]) last_side <= 1'b1;
      else if (mode[0] && !mode[2]) last_side <= 1'b0;
    end
  end

  // Duty targets from state and tracker mode
  always_comb begin
    tgt_l = 10'd0;
    tgt_r = 10'd0;
    case (cur_state)
      S_RUN: begin
        case (mode)
          3'b001:  begin tgt_l = 10'd1000; tgt_r = 10'd700;  end
          3'b011:  begin tgt_l = 10'd1000; tgt_r = 10'd850;  end
          3'b100:  begin tgt_l = 10'd850;  tgt_r = 10'd1000; end
          3'b110:  begin tgt_l = 10'd700;  tgt_r = 10'd1000; end
          3'b000:  begin tgt_l = 10'd600;  tgt_r = 10'd600;  end
          default: begin tgt_l = 10'd1000; tgt_r = 10'd1000; end
        endcase
      end
      S_SEARCH: begin
        if (last_side) begin tgt_l = SEARCH_SLOW; tgt_r = SEARCH_FAST; end
        else begin tgt_l = SEARCH_FAST; tgt_r = SEARCH_SLOW; end
      end
      default: begin tgt_l = 10'd0; tgt_r = 10'd0; end
    endcase
  end

  // Next state and timer values; stop overrides every other event
  always_comb begin
    nxt_state  = cur_state;
    lost_nxt   = lost_cnt;
    search_nxt = search_cnt;
    if (stop && cur_state != S_IDLE) begin
      nxt_state = S_IDLE;
    end else begin
      case (cur_state)
        S_IDLE, S_HALT: begin
          if (start_edge && !stop) begin
            nxt_state = S_RUN;
            lost_nxt  = 16'd0;
          end
        end
        S_RUN: begin
          if (tick) begin
            if (mode == 3'b000) begin
              lost_nxt = lost_inc;
              if (lost_inc >= LOST_TICKS) begin
                nxt_state  = S_SEARCH;
                search_nxt = 16'd0;
              end
            end else begin
              lost_nxt = 16'd0;
            end
          end
        end
        S_SEARCH: begin
          if (mode != 3'b000) begin
            nxt_state = S_RUN;
            lost_nxt  = 16'd0;
          end else if (tick) begin
            search_nxt = search_inc;
            if (search_inc >= SEARCH_TICKS) nxt_state = S_HALT;
          end
        end
        default: nxt_state = S_IDLE;
      endcase
    end
  end

  // State and timer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_state  <= S_IDLE;
      lost_cnt   <= 16'd0;
      search_cnt <= 16'd0;
    end else begin
      cur_state  <= nxt_state;
      lost_cnt   <= lost_nxt;
      search_cnt <= search_nxt;
    end
  end

  // Slew applied duties toward targets once per tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      left_duty  <= 10'd0;
      right_duty <= 10'd0;
    end else if (tick) begin
      left_duty  <= ramp_step(left_duty, tgt_l);
      right_duty <= ramp_step(right_duty, tgt_r);
    end
  end

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// tb/tb_motor_ramp_ctrl.sv - directed self-checking bench for motor_ramp_ctrl
module tb_motor_ramp_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [2:0] mode = 3'b000;
  logic [9:0] left_duty;
  logic [9:0] right_duty;
  logic [1:0] state;
  logic       at_target;

  int total  = 0;
  int passed = 0;
  int ecount = 0;

  always #5 clk = ~clk;

  motor_ramp_ctrl #(
    .TICK_DIV(4),
    .STEP(10'd100),
    .LOST_TICKS(16'd3),
    .SEARCH_TICKS(16'd5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .mode(mode),
    .left_duty(left_duty),
    .right_duty(right_duty),
    .state(state),
    .at_target(at_target)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ecount++;
  endtask

  // Every fourth edge after reset release is a ramp tick
  task automatic next_tick();
    do step(); while (ecount % 4 != 0);
  endtask

  initial begin
    #1 rst = 1'b0;
    #1;
    chk("reset_state", 16'(state), 16'd0);
    chk("reset_left", 16'(left_duty), 16'd0);
    chk("reset_right", 16'(right_duty), 16'd0);
    chk("reset_at_target", 16'(at_target), 16'd1);
    #10;
    rst = 1'b1;
    ecount = 0;

    // Start edge, full-speed ramp up
    mode = 3'b111;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_run", 16'(state), 16'd1);
    for (int k = 1; k <= 10; k++) begin
      next_tick();
      chk("ramp_up_left", 16'(left_duty), 16'(100 * k));
      chk("ramp_up_right", 16'(right_duty), 16'(100 * k));
    end
    chk("ramp_up_at_target", 16'(at_target), 16'd1);
    next_tick();
    chk("hold_left", 16'(left_duty), 16'd1000);
    chk("hold_right", 16'(right_duty), 16'd1000);

    // Gentle right turn
    mode = 3'b001;
    for (int k = 1; k <= 3; k++) begin
      next_tick();
      chk("turn_left", 16'(left_duty), 16'd1000);
      chk("turn_right", 16'(right_duty), 16'(1000 - 100 * k));
      chk("turn_at_target", 16'(at_target), (k == 3) ? 16'd1 : 16'd0);
    end

    // Line seen left, then lost for three ticks
    mode = 3'b100;
    step();
    mode = 3'b000;
    next_tick();
    chk("lost1_left", 16'(left_duty), 16'd900);
    chk("lost1_right", 16'(right_duty), 16'd600);
    next_tick();
    chk("lost2_state", 16'(state), 16'd1);
    chk("lost2_left", 16'(left_duty), 16'd800);
    next_tick();
    chk("lost3_state", 16'(state), 16'd2);
    chk("lost3_left", 16'(left_duty), 16'd700);
    chk("lost3_right", 16'(right_duty), 16'd600);
    next_tick();
    chk("search_left", 16'(left_duty), 16'd600);
    chk("search_right", 16'(right_duty), 16'd700);
    mode = 3'b010;
    step();
    chk("regain_state", 16'(state), 16'd1);

    // Lost again: SEARCH, then HALT after five search ticks
    mode = 3'b000;
    for (int k = 1; k <= 3; k++) next_tick();
    chk("relost_state", 16'(state), 16'd2);
    chk("relost_left", 16'(left_duty), 16'd600);
    chk("relost_right", 16'(right_duty), 16'd600);
    for (int k = 1; k <= 5; k++) begin
      next_tick();
      chk("srch_left", 16'(left_duty), (600 - 100 * k > 200) ? 16'(600 - 100 * k) : 16'd200);
      chk("srch_right", 16'(right_duty), 16'd700);
      chk("srch_state", 16'(state), (k == 5) ? 16'd3 : 16'd2);
    end
    for (int k = 1; k <= 7; k++) begin
      next_tick();
      chk("halt_left", 16'(left_duty), (200 - 100 * k > 0) ? 16'(200 - 100 * k) : 16'd0);
      chk("halt_right", 16'(right_duty), 16'(700 - 100 * k));
    end
    chk("halt_state", 16'(state), 16'd3);
    chk("halt_at_target", 16'(at_target), 16'd1);
    mode = 3'b111;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("halt_restart", 16'(state), 16'd1);

    // Ramp to full, then stop ramps down in IDLE
    for (int k = 1; k <= 10; k++) next_tick();
    chk("full_left", 16'(left_duty), 16'd1000);
    stop = 1'b1;
    step();
    chk("stop_state", 16'(state), 16'd0);
    chk("stop_not_instant", 16'(left_duty), 16'd1000);
    for (int k = 1; k <= 10; k++) begin
      next_tick();
      chk("down_left", 16'(left_duty), 16'(1000 - 100 * k));
      chk("down_right", 16'(right_duty), 16'(1000 - 100 * k));
    end
    start = 1'b1;
    step();
    chk("stop_beats_start", 16'(state), 16'd0);
    start = 1'b0;
    stop = 1'b0;
    step();
    chk("idle_no_edge", 16'(state), 16'd0);

    // Asynchronous reset in the middle of a ramp
    start = 1'b1;
    step();
    start = 1'b0;
    chk("run_again", 16'(state), 16'd1);
    for (int k = 1; k <= 5; k++) next_tick();
    chk("mid_left", 16'(left_duty), 16'd500);
    #2 rst = 1'b0;
    #1;
    chk("async_state", 16'(state), 16'd0);
    chk("async_left", 16'(left_duty), 16'd0);
    chk("async_right", 16'(right_duty), 16'd0);
    chk("async_at_target", 16'(at_target), 16'd1);
    #10 rst = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
